branch_tournament: RTL and testbench
====================================

BRANCH_TOURNAMENT -- requirements
Module: branch_tournament

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, log2 of the depth of each predictor table (2^INDEX_W entries).
REQ-002 SHALL have parameter CTR_W, default 2, width of every saturating counter (predictor and chooser).
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: lk_valid  in  1  lookup request; lk_pc  in  32  fetch PC.
REQ-006 SHALL have ports: pred_valid  out  1; pred_taken  out  1  final prediction; pred1  out  1  bimodal; pred2  out  1  gshare; pred_ghr  out  INDEX_W  history used.
REQ-007 SHALL have ports: res_valid  in  1; res_inst  in  32  resolved instruction; res_pc  in  32; res_taken  in  1  actual outcome (PCsel).
REQ-008 SHALL have ports: res_pred, res_p1, res_p2  in  1 each  predictions carried down the pipeline; res_ghr  in  INDEX_W.
REQ-009 SHALL have ports: mispredict, miss1, miss2  out  1 each  registered flags; stat_clr  in  1; branch_cnt, miss_cnt  out  CNT_W.

Function
REQ-010 SHALL compute bim_idx = pc[INDEX_W+1:2] and gsh_idx = pc[INDEX_W+1:2] XOR ghr.
REQ-011 SHALL hold three tables of 2^INDEX_W CTR_W-bit counters: BIM (bim_idx), GSH (gsh_idx), CHO (bim_idx); one INDEX_W-bit global history register GHR.
REQ-012 SHALL register lookup results one cycle after lk_valid: pred_valid=1, pred1=BIM MSB, pred2=GSH MSB (indexed with current GHR), pred_ghr=GHR, pred_taken = CHO MSB ? pred2 : pred1.
REQ-013 SHALL drive pred_valid=0 in any cycle following lk_valid=0; pred1/pred2/pred_taken/pred_ghr hold their last values.
REQ-014 SHALL qualify resolution as branch only when res_valid=1 and res_inst[6:0]=7'b1100011.
REQ-015 SHALL, on a qualified resolution, register next cycle: mispredict=(res_taken!=res_pred), miss1=(res_taken!=res_p1), miss2=(res_taken!=res_p2).
REQ-016 SHALL drive mispredict, miss1, miss2 to 0 in every cycle not following a qualified resolution (single-cycle pulses).
REQ-017 SHALL, on a qualified resolution, update BIM[res_pc idx] and GSH[res_pc idx XOR res_ghr]: +1 if res_taken, -1 otherwise, saturating at 0 and 2^CTR_W-1.
REQ-018 SHALL update CHO[bim_idx of res_pc] +1 (saturating) when miss1=1 and miss2=0, -1 (saturating) when miss1=0 and miss2=1, else unchanged.
REQ-019 SHALL shift GHR on a qualified resolution: GHR <= {GHR[INDEX_W-2:0], res_taken}; GHR is non-speculative.
REQ-020 SHALL return pre-update table contents when lookup and update hit the same entry in the same cycle (no bypass).
REQ-021 SHALL leave all tables, GHR and statistics unchanged on non-qualified resolutions.
REQ-022 SHALL increment branch_cnt per qualified resolution and miss_cnt per qualified resolution with mispredict, each saturating at 2^CNT_W-1.
REQ-023 SHALL clear both statistics counters on stat_clr; stat_clr has priority over a same-cycle increment.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, set every BIM, GSH and CHO entry to 2^(CTR_W-1)-1 (weakly not-taken / weakly favour bimodal), GHR=0.
REQ-025 SHALL, on reset, clear pred_valid, pred_taken, pred1, pred2, pred_ghr, mispredict, miss1, miss2, branch_cnt, miss_cnt.
REQ-026 SHALL give rst priority over lk_valid, res_valid and stat_clr in the same cycle.

Verification
REQ-027 SHALL cover: reset, lk_pc=0x100 -> next cycle pred_valid=1, pred1=pred2=pred_taken=0, pred_ghr=0.
REQ-028 SHALL cover: two qualified resolutions pc=0x100 res_taken=1, all preds 0, res_ghr=0 -> BIM[0] 01->10->11, mispredict/miss1/miss2 pulse each time, GHR=2'b11 in low bits, branch_cnt=2, miss_cnt=2.
REQ-029 SHALL cover: res_valid=1, res_inst[6:0]=0x33 -> no flags, tables/GHR/counters unchanged.
REQ-030 SHALL cover: saturation -- BIM entry at 3 resolved taken stays 3; at 0 resolved not-taken stays 0.
REQ-031 SHALL cover: res_p1=0, res_p2=1, res_taken=1 -> CHO 01->10, subsequent lookup pred_taken follows pred2.
REQ-032 SHALL cover: rst asserted together with qualified res_valid and lk_valid -> all tables at reset value, outputs 0 next cycle.

Source files
------------

// File: rtl/branch_tournament.sv
// ============================================================================
// Module   : branch_tournament
// Brief    : Tournament branch predictor. A bimodal table and a gshare table
//            each vote, and a chooser table picks which vote to trust. Tables
//            learn from resolved conditional branches. Mispredict statistics
//            are kept alongside.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_tournament #(
  parameter int INDEX_W = 6,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  // lookup side
  input  logic               lk_valid,
  input  logic [31:0]        lk_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic               pred1,
  output logic               pred2,
  output logic [INDEX_W-1:0] pred_ghr,
  // resolution side
  input  logic               res_valid,
  input  logic [31:0]        res_inst,
  input  logic [31:0]        res_pc,
  input  logic               res_taken,
  input  logic               res_pred,
  input  logic               res_p1,
  input  logic               res_p2,
  input  logic [INDEX_W-1:0] res_ghr,
  output logic               mispredict,
  output logic               miss1,
  output logic               miss2,
  // statistics
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int               c_DEPTH    = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] c_CTR_MIN  = '0;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [6:0]       c_OP_BRANCH = 7'b1100011;

  logic [CTR_W-1:0]   r_bim [c_DEPTH];
  logic [CTR_W-1:0]   r_gsh [c_DEPTH];
  logic [CTR_W-1:0]   r_cho [c_DEPTH];
  logic [INDEX_W-1:0] r_ghr;

  logic               r_pred_valid, r_pred_taken, r_pred1, r_pred2;
  logic [INDEX_W-1:0] r_pred_ghr;
  logic               r_mispredict, r_miss1, r_miss2;
  logic [CNT_W-1:0]   r_branch_cnt, r_miss_cnt;

  logic [INDEX_W-1:0] w_lk_bidx, w_lk_gidx, w_res_bidx, w_res_gidx;
  logic               w_lk_p1, w_lk_p2, w_lk_cho;
  logic               w_qual, w_mis, w_mis1, w_mis2;
  logic               w_unused;

  // Saturating counter steps
  function automatic logic [CTR_W-1:0] f_inc(input logic [CTR_W-1:0] v);
    return (v == c_CTR_MAX) ? v : v + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] f_dec(input logic [CTR_W-1:0] v);
    return (v == c_CTR_MIN) ? v : v - CTR_W'(1);
  endfunction

  assign w_lk_bidx  = lk_pc[INDEX_W+1:2];
  assign w_lk_gidx  = w_lk_bidx ^ r_ghr;
  assign w_res_bidx = res_pc[INDEX_W+1:2];
  assign w_res_gidx = w_res_bidx ^ res_ghr;

  // Table reads use the current contents, so a same-cycle update is not seen
  assign w_lk_p1  = r_bim[w_lk_bidx][CTR_W-1];
  assign w_lk_p2  = r_gsh[w_lk_gidx][CTR_W-1];
  assign w_lk_cho = r_cho[w_lk_bidx][CTR_W-1];

  assign w_qual = res_valid && (res_inst[6:0] == c_OP_BRANCH);
  assign w_mis  = res_taken != res_pred;
  assign w_mis1 = res_taken != res_p1;
  assign w_mis2 = res_taken != res_p2;

  // Address bits outside the index field and non-opcode bits are not needed
  assign w_unused = ^{lk_pc[31:INDEX_W+2], lk_pc[1:0],
                      res_pc[31:INDEX_W+2], res_pc[1:0], res_inst[31:7]};

  // Predictor tables, chooser and global history: train on qualified branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_bim[i] <= c_CTR_INIT;
        r_gsh[i] <= c_CTR_INIT;
        r_cho[i] <= c_CTR_INIT;
      end
      r_ghr <= '0;
    end else if (w_qual) begin
      r_bim[w_res_bidx] <= res_taken ? f_inc(r_bim[w_res_bidx]) : f_dec(r_bim[w_res_bidx]);
      r_gsh[w_res_gidx] <= res_taken ? f_inc(r_gsh[w_res_gidx]) : f_dec(r_gsh[w_res_gidx]);
      // Chooser moves toward whichever component alone got it right
      if (w_mis1 && !w_mis2) begin
        r_cho[w_res_bidx] <= f_inc(r_cho[w_res_bidx]);
      end else if (!w_mis1 && w_mis2) begin
        r_cho[w_res_bidx] <= f_dec(r_cho[w_res_bidx]);
      end
      r_ghr <= {r_ghr[INDEX_W-2:0], res_taken};
    end
  end

  // Registered lookup result; prediction fields hold when no lookup arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred1      <= 1'b0;
      r_pred2      <= 1'b0;
      r_pred_ghr   <= '0;
    end else begin
      r_pred_valid <= lk_valid;
      if (lk_valid) begin
        r_pred1      <= w_lk_p1;
        r_pred2      <= w_lk_p2;
        r_pred_ghr   <= r_ghr;
        r_pred_taken <= w_lk_cho ? w_lk_p2 : w_lk_p1;
      end
    end
  end

  // Single-cycle miss flags following each qualified resolution
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict <= 1'b0;
      r_miss1      <= 1'b0;
      r_miss2      <= 1'b0;
    end else begin
      r_mispredict <= w_qual && w_mis;
      r_miss1      <= w_qual && w_mis1;
      r_miss2      <= w_qual && w_mis2;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_qual) begin
      if (r_branch_cnt != c_CNT_MAX) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mis && (r_miss_cnt != c_CNT_MAX)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred1      = r_pred1;
  assign pred2      = r_pred2;
  assign pred_ghr   = r_pred_ghr;
  assign mispredict = r_mispredict;
  assign miss1      = r_miss1;
  assign miss2      = r_miss2;
  assign branch_cnt = r_branch_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_tournament.sv
// ============================================================================
// Module   : tb_branch_tournament
// Brief    : Self-checking bench for branch_tournament: directed scenarios
//            followed by randomized traffic, compared each cycle against an
//            array-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_tournament;

  localparam int INDEX_W = 6;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 6;
  localparam int DEPTH   = 1 << INDEX_W;
  localparam int CTR_MAX = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst, lk_valid, res_valid, res_taken, res_pred, res_p1, res_p2, stat_clr;
  logic [31:0]        lk_pc, res_inst, res_pc;
  logic [INDEX_W-1:0] res_ghr;
  logic               pred_valid, pred_taken, pred1, pred2, mispredict, miss1, miss2;
  logic [INDEX_W-1:0] pred_ghr;
  logic [CNT_W-1:0]   branch_cnt, miss_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int m_bim [DEPTH];
  int m_gsh [DEPTH];
  int m_cho [DEPTH];
  int m_ghr;
  int e_pv, e_pt, e_p1, e_p2, e_pghr, e_mp, e_m1, e_m2, e_bc, e_mc;

  branch_tournament #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred1(pred1), .pred2(pred2),
    .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_inst(res_inst), .res_pc(res_pc), .res_taken(res_taken),
    .res_pred(res_pred), .res_p1(res_p1), .res_p2(res_p2), .res_ghr(res_ghr),
    .mispredict(mispredict), .miss1(miss1), .miss2(miss2),
    .stat_clr(stat_clr), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic t_check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int f_sat(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Advance one clock: predict expected outputs from the rules, then compare
  task automatic t_tick();
    int bi, gi, rb, rg, qual;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_bim[i] = CTR_HALF - 1; m_gsh[i] = CTR_HALF - 1; m_cho[i] = CTR_HALF - 1;
      end
      m_ghr = 0;
      e_pv = 0; e_pt = 0; e_p1 = 0; e_p2 = 0; e_pghr = 0;
      e_mp = 0; e_m1 = 0; e_m2 = 0; e_bc = 0; e_mc = 0;
    end else begin
      // lookup sees tables before this cycle's training
      e_pv = lk_valid;
      if (lk_valid) begin
        bi = (lk_pc / 4) % DEPTH;
        gi = bi ^ m_ghr;
        e_p1 = (m_bim[bi] >= CTR_HALF);
        e_p2 = (m_gsh[gi] >= CTR_HALF);
        e_pt = (m_cho[bi] >= CTR_HALF) ? e_p2 : e_p1;
        e_pghr = m_ghr;
      end
      qual = res_valid && (res_inst % 128 == 'h63);
      e_mp = qual && (res_taken != res_pred);
      e_m1 = qual && (res_taken != res_p1);
      e_m2 = qual && (res_taken != res_p2);
      if (qual) begin
        rb = (res_pc / 4) % DEPTH;
        rg = rb ^ int'(res_ghr);
        m_bim[rb] = f_sat(m_bim[rb] + (res_taken ? 1 : -1), 0, CTR_MAX);
        m_gsh[rg] = f_sat(m_gsh[rg] + (res_taken ? 1 : -1), 0, CTR_MAX);
        if (e_m1 && !e_m2) m_cho[rb] = f_sat(m_cho[rb] + 1, 0, CTR_MAX);
        if (!e_m1 && e_m2) m_cho[rb] = f_sat(m_cho[rb] - 1, 0, CTR_MAX);
        m_ghr = (m_ghr * 2 + int'(res_taken)) % DEPTH;
      end
      if (stat_clr) begin
        e_bc = 0; e_mc = 0;
      end else if (qual) begin
        e_bc = f_sat(e_bc + 1, 0, CNT_MAX);
        e_mc = f_sat(e_mc + e_mp, 0, CNT_MAX);
      end
    end
    @(posedge clk);
    #1;
    t_check("pred_valid", int'(pred_valid), e_pv);
    t_check("pred_taken", int'(pred_taken), e_pt);
    t_check("pred1", int'(pred1), e_p1);
    t_check("pred2", int'(pred2), e_p2);
    t_check("pred_ghr", int'(pred_ghr), e_pghr);
    t_check("mispredict", int'(mispredict), e_mp);
    t_check("miss1", int'(miss1), e_m1);
    t_check("miss2", int'(miss2), e_m2);
    t_check("branch_cnt", int'(branch_cnt), e_bc);
    t_check("miss_cnt", int'(miss_cnt), e_mc);
  endtask

  task automatic t_idle();
    rst = 0; lk_valid = 0; res_valid = 0; stat_clr = 0;
  endtask

  task automatic t_res(input logic [31:0] pc, input logic tk, input logic p,
                       input logic p1, input logic p2, input logic [INDEX_W-1:0] g);
    res_valid = 1; res_inst = 32'h0000_0063; res_pc = pc; res_taken = tk;
    res_pred = p; res_p1 = p1; res_p2 = p2; res_ghr = g;
  endtask

  initial begin
    rst = 1; lk_valid = 0; lk_pc = 0; res_valid = 0; res_inst = 0; res_pc = 0;
    res_taken = 0; res_pred = 0; res_p1 = 0; res_p2 = 0; res_ghr = 0; stat_clr = 0;

    // reset state
    t_tick();
    t_check("rst_pred_valid", int'(pred_valid), 0);

    // first lookup after reset: weakly not-taken everywhere
    t_idle(); lk_valid = 1; lk_pc = 32'h100;
    t_tick();
    t_check("lk0_valid", int'(pred_valid), 1);
    t_check("lk0_taken", int'(pred_taken), 0);

    // two taken resolutions at 0x100 with all predictions wrong
    t_idle(); t_res(32'h100, 1, 0, 0, 0, 0);
    t_tick();
    t_check("r1_mispredict", int'(mispredict), 1);
    t_tick();
    t_check("r2_miss2", int'(miss2), 1);
    t_idle(); lk_valid = 1; lk_pc = 32'h100;
    t_tick();
    t_check("bim_trained", int'(pred1), 1);
    t_check("ghr_11", int'(pred_ghr), 3);
    t_check("bcnt2", int'(branch_cnt), 2);

    // non-branch opcode leaves everything untouched
    t_idle(); t_res(32'h100, 0, 1, 1, 1, 0); res_inst = 32'h0000_0033;
    t_tick();
    t_check("nonbr_flag", int'(mispredict), 0);

    // saturation at max, then one step down keeps taken
    t_idle(); t_res(32'h100, 1, 1, 1, 1, 0);
    t_tick();
    t_res(32'h100, 0, 1, 1, 1, 0);
    t_tick();
    t_idle(); lk_valid = 1; lk_pc = 32'h100;
    t_tick();
    t_check("bim_sat_hi", int'(pred1), 1);

    // saturation at zero on an untouched entry
    t_idle(); t_res(32'h104, 0, 0, 0, 0, 0);
    t_tick(); t_tick(); t_tick();
    t_res(32'h104, 1, 0, 0, 0, 0);
    t_tick();
    t_idle(); lk_valid = 1; lk_pc = 32'h104;
    t_tick();
    t_check("bim_sat_lo", int'(pred1), 0);

    // chooser moves toward gshare when only gshare was right
    t_idle(); t_res(32'h108, 1, 0, 0, 1, 0);
    t_tick();
    t_idle(); lk_valid = 1; lk_pc = 32'h108;
    t_tick();
    t_check("cho_follow_p2", int'(pred_taken), int'(pred2));

    // reset colliding with lookup and resolution
    t_idle(); rst = 1; lk_valid = 1; lk_pc = 32'h100; t_res(32'h100, 1, 0, 0, 0, 0);
    t_tick();
    t_check("rst_prio_valid", int'(pred_valid), 0);
    t_check("rst_prio_flag", int'(mispredict), 0);
    t_idle(); lk_valid = 1; lk_pc = 32'h100;
    t_tick();
    t_check("rst_prio_tables", int'(pred1), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 499) == 0);
      stat_clr  = ($urandom_range(0, 149) == 0);
      lk_valid  = $urandom_range(0, 1);
      lk_pc     = ($urandom & ~32'h0000_00FC) | ($urandom_range(0, 15) << 2);
      res_valid = ($urandom_range(0, 3) != 0);
      res_inst  = ($urandom_range(0, 3) != 0) ? (($urandom & ~32'h7F) | 32'h63) : $urandom;
      res_pc    = ($urandom & ~32'h0000_00FC) | ($urandom_range(0, 15) << 2);
      res_taken = $urandom_range(0, 1);
      res_pred  = $urandom_range(0, 1);
      res_p1    = $urandom_range(0, 1);
      res_p2    = $urandom_range(0, 1);
      res_ghr   = $urandom_range(0, 1) ? INDEX_W'(e_pghr) : INDEX_W'($urandom_range(0, DEPTH - 1));
      t_tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
